bp_fe_fetch_replay_queue: RTL and testbench

Parametrised fetch replay queue between the front-end fetch-address source and `bp_fe_icache`. It buffers translated fetch requests (vaddr, ptag, attributes) and issues them in order to the I$. Each issued request is tracked through a fixed-latency pipeline. When the I$ does not return data for the oldest in-flight request, the queue rolls issue back to that request. It supersedes the fixed 8-entry rolly FIFO plus ad-hoc 2-stage yumi chain with configurable depth and latency, flush, replay accounting and livelock detection.

---
 rtl/bp_fe_pkg.sv | 33 +++
 rtl/bsg_mem_1r1w.sv | 44 ++++
 rtl/bp_fe_fetch_replay_queue.sv | 153 +++++++++++++++
 tb/tb_bp_fe_fetch_replay_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// ---------------------------------------------------------------------------
// bp_fe_pkg
// Shared front-end types for the fetch replay queue.
//   bp_fe_fetch_attr_s          : per-request attributes {dram, nonidem, uncached}
//   DECLARE_BP_FE_FETCH_ENTRY_S : macro that declares the stored queue entry
//                                 (vaddr, ptag, attr) for given widths
// ---------------------------------------------------------------------------

`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

// The entry layout depends on the instantiating module's width parameters,
// so it is declared through a macro rather than as a fixed package type.
`define DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_mp, ptag_width_mp) \
    typedef struct packed {                                       \
        logic [vaddr_width_mp-1:0] vaddr;                         \
        logic [ptag_width_mp-1:0]  ptag;                          \
        bp_fe_fetch_attr_s         attr;                          \
    } bp_fe_fetch_entry_s

package bp_fe_pkg;

    localparam int bp_fe_fetch_attr_width_gp = 3;

    typedef struct packed {
        logic dram;
        logic nonidem;
        logic uncached;
    } bp_fe_fetch_attr_s;

endpackage

`endif

// File: rtl/bsg_mem_1r1w.sv
// ---------------------------------------------------------------------------
// bsg_mem_1r1w
// One synchronous write port, one asynchronous read port register array.
//   w_clk_i   : write clock
//   w_v_i     : write enable
//   w_addr_i  : write address
//   w_data_i  : write data
//   r_addr_i  : read address
//   r_data_o  : read data (combinational)
// With read_write_same_addr_p=0 a read of the address being written returns
// the old contents; with 1 the write data is forwarded.
// ---------------------------------------------------------------------------
module bsg_mem_1r1w #(
    parameter int width_p                = 8,
    parameter int els_p                  = 8,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // Storage carries no reset: the queue pointers decide what is valid.
    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    // Optional write-through forwarding on an address collision.
    always_comb begin
        r_data_o = mem_r[r_addr_i];
        if ((read_write_same_addr_p != 0) && w_v_i && (w_addr_i == r_addr_i)) begin
            r_data_o = w_data_i;
        end
    end

endmodule

// File: rtl/bp_fe_fetch_replay_queue.sv
// ---------------------------------------------------------------------------
// bp_fe_fetch_replay_queue
// Buffers translated fetch requests and issues them in order to the I$.
// Every issued request is tracked through a fixed-latency shift register;
// if the I$ has not returned data when the oldest request comes due, issue
// rolls back to that request and everything younger is reissued.
//   clk_i, reset_i            : clock, async active-high reset
//   flush_i                   : synchronous discard of all state
//   vaddr_i/ptag_i/attr_i/v_i : enqueue side, ready_o back-pressure
//   vaddr_o/ptag_o/attr_o     : entry at the issue pointer
//   issue_v_o/issue_ready_i   : issue handshake
//   data_v_i                  : I$ returned data for the oldest tracked request
//   replay_o                  : pulse on rollback
//   stall_err_o               : sticky livelock flag
//   count_o                   : entries enqueued but not committed
// ---------------------------------------------------------------------------
module bp_fe_fetch_replay_queue
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int ptag_width_p   = 28,
    parameter int els_p          = 8,
    parameter int latency_p      = 2,
    parameter int replay_limit_p = 15
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 flush_i,
    input  logic [vaddr_width_p-1:0]             vaddr_i,
    input  logic [ptag_width_p-1:0]              ptag_i,
    input  logic [bp_fe_fetch_attr_width_gp-1:0] attr_i,
    input  logic                                 v_i,
    output logic                                 ready_o,
    output logic [vaddr_width_p-1:0]             vaddr_o,
    output logic [ptag_width_p-1:0]              ptag_o,
    output logic [bp_fe_fetch_attr_width_gp-1:0] attr_o,
    output logic                                 issue_v_o,
    input  logic                                 issue_ready_i,
    input  logic                                 data_v_i,
    output logic                                 replay_o,
    output logic                                 stall_err_o,
    output logic [$clog2(els_p):0]               count_o
);

    localparam int idx_width_lp        = $clog2(els_p);
    localparam int ptr_width_lp        = idx_width_lp + 1;
    localparam int replay_cnt_width_lp = $clog2(replay_limit_p + 1);

    `DECLARE_BP_FE_FETCH_ENTRY_S(vaddr_width_p, ptag_width_p);
    localparam int entry_width_lp = $bits(bp_fe_fetch_entry_s);

    logic [ptr_width_lp-1:0]        wptr_r, iptr_r, cptr_r;
    logic [latency_p-1:0]           inflight_r;
    logic [replay_cnt_width_lp-1:0] replay_cnt_r, replay_cnt_next;
    logic                           stall_err_r;

    logic full, enq_fire, issue_fire, due, commit, rollback;
    bp_fe_fetch_entry_s             wr_entry, rd_entry;
    logic [entry_width_lp-1:0]      rd_data;

    // Full when the indices match but the wrap bits differ.
    assign full = (wptr_r[idx_width_lp-1:0] == cptr_r[idx_width_lp-1:0])
                & (wptr_r[idx_width_lp] != cptr_r[idx_width_lp]);

    assign due      = inflight_r[latency_p-1];
    assign commit   = due & data_v_i & ~flush_i;
    assign rollback = due & ~data_v_i & ~flush_i;

    assign ready_o    = ~full & ~flush_i;
    assign enq_fire   = v_i & ready_o;
    assign issue_v_o  = (iptr_r != wptr_r) & ~rollback & ~flush_i;
    assign issue_fire = issue_v_o & issue_ready_i;

    assign replay_o    = rollback;
    assign stall_err_o = stall_err_r;
    assign count_o     = wptr_r - cptr_r;

    assign wr_entry.vaddr = vaddr_i;
    assign wr_entry.ptag  = ptag_i;
    assign wr_entry.attr  = bp_fe_fetch_attr_s'(attr_i);

    bsg_mem_1r1w #(
        .width_p               (entry_width_lp),
        .els_p                 (els_p),
        .read_write_same_addr_p(0)
    ) mem (
        .w_clk_i  (clk_i),
        .w_v_i    (enq_fire),
        .w_addr_i (wptr_r[idx_width_lp-1:0]),
        .w_data_i (wr_entry),
        .r_addr_i (iptr_r[idx_width_lp-1:0]),
        .r_data_o (rd_data)
    );

    assign rd_entry = bp_fe_fetch_entry_s'(rd_data);
    assign vaddr_o  = rd_entry.vaddr;
    assign ptag_o   = rd_entry.ptag;
    assign attr_o   = rd_entry.attr;

    // Replay counter saturates so a stuck head keeps the error raised
    // without wrapping back below the limit.
    always_comb begin
        replay_cnt_next = replay_cnt_r;
        if (replay_cnt_r != replay_cnt_width_lp'(replay_limit_p)) begin
            replay_cnt_next = replay_cnt_r + 1'b1;
        end
    end

    // Pointer, tracker and replay bookkeeping. Flush dominates everything;
    // otherwise commit and rollback are mutually exclusive (both need the
    // due stage) and enqueue proceeds independently of either.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r       <= '0;
            iptr_r       <= '0;
            cptr_r       <= '0;
            inflight_r   <= '0;
            replay_cnt_r <= '0;
            stall_err_r  <= 1'b0;
        end else if (flush_i) begin
            wptr_r       <= '0;
            iptr_r       <= '0;
            cptr_r       <= '0;
            inflight_r   <= '0;
            replay_cnt_r <= '0;
            stall_err_r  <= 1'b0;
        end else begin
            if (enq_fire) begin
                wptr_r <= wptr_r + 1'b1;
            end

            if (rollback) begin
                iptr_r       <= cptr_r;
                inflight_r   <= '0;
                replay_cnt_r <= replay_cnt_next;
                if (replay_cnt_next == replay_cnt_width_lp'(replay_limit_p)) begin
                    stall_err_r <= 1'b1;
                end
            end else begin
                inflight_r <= (inflight_r << 1) | latency_p'(issue_fire);
                if (issue_fire) begin
                    iptr_r <= iptr_r + 1'b1;
                end
            end

            if (commit) begin
                cptr_r       <= cptr_r + 1'b1;
                replay_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_fetch_replay_queue.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_fetch_replay_queue
// Randomised bench for the fetch replay queue. A reference model keeps the
// uncommitted requests in a queue, counts how many past the head have been
// issued, and keeps the due cycle of every tracked request.
// ---------------------------------------------------------------------------
module tb_bp_fe_fetch_replay_queue;

    localparam int VW  = 39;
    localparam int PW  = 28;
    localparam int ELS = 8;
    localparam int LAT = 2;
    localparam int LIM = 15;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          flush_i;
    logic [VW-1:0] vaddr_i;
    logic [PW-1:0] ptag_i;
    logic [2:0]    attr_i;
    logic          v_i;
    logic          ready_o;
    logic [VW-1:0] vaddr_o;
    logic [PW-1:0] ptag_o;
    logic [2:0]    attr_o;
    logic          issue_v_o;
    logic          issue_ready_i;
    logic          data_v_i;
    logic          replay_o;
    logic          stall_err_o;
    logic [3:0]    count_o;

    bp_fe_fetch_replay_queue #(
        .vaddr_width_p (VW),
        .ptag_width_p  (PW),
        .els_p         (ELS),
        .latency_p     (LAT),
        .replay_limit_p(LIM)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .vaddr_i      (vaddr_i),
        .ptag_i       (ptag_i),
        .attr_i       (attr_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .vaddr_o      (vaddr_o),
        .ptag_o       (ptag_o),
        .attr_o       (attr_o),
        .issue_v_o    (issue_v_o),
        .issue_ready_i(issue_ready_i),
        .data_v_i     (data_v_i),
        .replay_o     (replay_o),
        .stall_err_o  (stall_err_o),
        .count_o      (count_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [VW-1:0] vaddr;
        logic [PW-1:0] ptag;
        logic [2:0]    attr;
    } ent_t;

    // Reference model state.
    ent_t mq[$];
    int   due_q[$];
    int   issued;
    int   replay_cnt;
    bit   stall;
    int   cyc;

    int   checks = 0;
    int   errors = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    task automatic modelClear();
        mq.delete();
        due_q.delete();
        issued     = 0;
        replay_cnt = 0;
        stall      = 1'b0;
    endtask

    function automatic bit modelDue();
        return (due_q.size() > 0) && (due_q[0] == cyc);
    endfunction

    // One clock cycle: called just after a falling edge. Drives inputs,
    // checks outputs against the model, then advances the model at the
    // rising edge and returns at the following falling edge.
    task automatic applyStimulus(input bit v, input bit ir, input bit dv, input bit fl);
        ent_t ne;
        bit   due_now, rb, exp_ready, exp_iv, fire_iss, enq;

        ne.vaddr = VW'({$urandom(), $urandom()});
        ne.ptag  = PW'($urandom());
        ne.attr  = 3'($urandom());

        v_i           = v;
        issue_ready_i = ir;
        data_v_i      = dv;
        flush_i       = fl;
        vaddr_i       = ne.vaddr;
        ptag_i        = ne.ptag;
        attr_i        = ne.attr;
        #1;

        due_now   = modelDue();
        rb        = due_now && !dv && !fl;
        exp_ready = (mq.size() < ELS) && !fl;
        exp_iv    = (issued < mq.size()) && !rb && !fl;

        checkOutput("count",   64'(count_o),     64'(mq.size()));
        checkOutput("ready",   64'(ready_o),     64'(exp_ready));
        checkOutput("issue_v", 64'(issue_v_o),   64'(exp_iv));
        checkOutput("replay",  64'(replay_o),    64'(rb));
        checkOutput("stall",   64'(stall_err_o), 64'(stall));
        if (exp_iv && issue_v_o) begin
            checkOutput("vaddr", 64'(vaddr_o), 64'(mq[issued].vaddr));
            checkOutput("ptag",  64'(ptag_o),  64'(mq[issued].ptag));
            checkOutput("attr",  64'(attr_o),  64'(mq[issued].attr));
        end

        @(posedge clk_i);
        if (fl) begin
            modelClear();
        end else begin
            fire_iss = exp_iv && ir;
            enq      = v && exp_ready;
            if (due_now && dv) begin
                void'(mq.pop_front());
                void'(due_q.pop_front());
                issued--;
                replay_cnt = 0;
            end else if (rb) begin
                issued = 0;
                due_q.delete();
                if (replay_cnt < LIM) replay_cnt++;
                if (replay_cnt == LIM) stall = 1'b1;
            end
            if (fire_iss) begin
                issued++;
                due_q.push_back(cyc + LAT);
            end
            if (enq) mq.push_back(ne);
        end
        cyc++;
        @(negedge clk_i);
    endtask

    // dv_mode: 0 = never return data, 1 = always return when due,
    // 2 = mostly return when due with occasional spurious data.
    task automatic runCycles(input int n, input int v_pct, input int ir_pct,
                             input int dv_mode, input int fl_pct);
        bit dv;
        for (int k = 0; k < n; k++) begin
            case (dv_mode)
                0:       dv = 1'b0;
                1:       dv = modelDue();
                default: dv = modelDue() ? ($urandom_range(0, 9) < 8)
                                         : ($urandom_range(0, 9) < 1);
            endcase
            applyStimulus($urandom_range(0, 99) < v_pct,
                          $urandom_range(0, 99) < ir_pct,
                          dv,
                          $urandom_range(0, 999) < fl_pct);
        end
    endtask

    // Reset asserted in the middle of a cycle while work is in flight:
    // outputs must drop to reset values without waiting for a clock edge.
    task automatic asyncResetMidCycle();
        v_i           = 1'b1;
        issue_ready_i = 1'b1;
        data_v_i      = 1'b0;
        flush_i       = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("async_count",   64'(count_o),     64'd0);
        checkOutput("async_ready",   64'(ready_o),     64'd1);
        checkOutput("async_issue_v", 64'(issue_v_o),   64'd0);
        checkOutput("async_replay",  64'(replay_o),    64'd0);
        checkOutput("async_stall",   64'(stall_err_o), 64'd0);
        @(posedge clk_i);
        modelClear();
        cyc++;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        flush_i       = 1'b0;
        v_i           = 1'b0;
        issue_ready_i = 1'b0;
        data_v_i      = 1'b0;
        vaddr_i       = '0;
        ptag_i        = '0;
        attr_i        = '0;
        cyc           = 0;
        modelClear();

        #12;
        checkOutput("rst_count",   64'(count_o),     64'd0);
        checkOutput("rst_ready",   64'(ready_o),     64'd1);
        checkOutput("rst_issue_v", 64'(issue_v_o),   64'd0);
        checkOutput("rst_replay",  64'(replay_o),    64'd0);
        checkOutput("rst_stall",   64'(stall_err_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // In-order issue and commit of three requests.
        runCycles(3, 100, 0, 1, 0);
        runCycles(10, 0, 100, 1, 0);

        // Head data withheld once: rollback and reissue of both.
        runCycles(2, 100, 0, 1, 0);
        runCycles(3, 0, 100, 0, 0);
        runCycles(10, 0, 100, 1, 0);

        // Fill to capacity, then drain with enqueue held.
        runCycles(10, 100, 0, 1, 0);
        runCycles(12, 100, 100, 1, 0);
        runCycles(12, 0, 100, 1, 0);

        // Livelock: repeated rollback of one head, then commit, then flush.
        runCycles(1, 0, 0, 1, 1000);
        runCycles(1, 100, 0, 1, 0);
        runCycles(60, 0, 100, 0, 0);
        runCycles(6, 0, 100, 1, 0);
        runCycles(1, 100, 0, 1, 1000);
        runCycles(2, 0, 0, 1, 0);

        // Flush with entries queued and in flight while enqueue is offered.
        runCycles(4, 100, 0, 1, 0);
        runCycles(2, 0, 100, 1, 0);
        runCycles(1, 100, 100, 1, 1000);
        runCycles(2, 0, 100, 1, 0);

        // Long randomised run.
        runCycles(2000, 60, 70, 2, 20);

        // Async reset with a request in flight; late data must be ignored.
        runCycles(2, 100, 0, 1, 0);
        runCycles(1, 0, 100, 1, 0);
        asyncResetMidCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        runCycles(50, 60, 70, 2, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
